// File: rtl/reg_file_lifo.sv
// LIFO stack controller in front of a single-port register file.
// Zero-fills the register file after reset and on clear, then serves push/pop requests.
module reg_file_lifo #(
    parameter int width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clr,
    input  logic [width-1:0]          push_data,
    output logic [width-1:0]          pop_data,
    output logic                      pop_valid,
    output logic [$clog2(width):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      busy,
    output logic                      ovf,
    output logic                      udf,
    output logic                      rf_wr_en,
    output logic [$clog2(width)-1:0]  rf_addr,
    output logic [width-1:0]          rf_wr_data,
    input  logic [width-1:0]          rf_rd_data
);

    localparam int M     = $clog2(width);
    localparam int DEPTH = 2 ** M;
    localparam logic [M:0]   SP_FULL = (M+1)'(DEPTH);
    localparam logic [M-1:0] K_LAST  = M'(DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_CLR} state_t;

    state_t       state, state_next;
    logic [M-1:0] k, k_next;
    logic [M:0]   sp, sp_next;
    logic         load_rd, load_byp, set_ovf, set_udf, clr_flags;
    logic         sp_empty, sp_full;

    assign sp_empty = (sp == '0);
    assign sp_full  = (sp == SP_FULL);
    assign busy     = (state != S_RUN);

    always_comb begin
        state_next = state;
        k_next     = k;
        sp_next    = sp;
        rf_wr_en   = 1'b0;
        rf_addr    = sp[M-1:0] - 1'b1;
        rf_wr_data = '0;
        load_rd    = 1'b0;
        load_byp   = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        clr_flags  = 1'b0;
        case (state)
            S_INIT, S_CLR: begin
                rf_wr_en = 1'b1;
                rf_addr  = k;
                k_next   = k + 1'b1;
                if (k == K_LAST) begin
                    state_next = S_RUN;
                    k_next     = '0;
                end
            end
            S_RUN: begin
                // Priority order matters: clear beats everything, replace-top beats plain push/pop.
                if (clr) begin
                    state_next = S_CLR;
                    k_next     = '0;
                    sp_next    = '0;
                    clr_flags  = 1'b1;
                end else if (push && pop && !sp_empty) begin
                    // Old top is read combinationally before the write lands at the edge.
                    rf_wr_en   = 1'b1;
                    rf_wr_data = push_data;
                    load_rd    = 1'b1;
                end else if (push && pop) begin
                    load_byp = 1'b1;
                end else if (push && !sp_full) begin
                    rf_wr_en   = 1'b1;
                    rf_addr    = sp[M-1:0];
                    rf_wr_data = push_data;
                    sp_next    = sp + 1'b1;
                end else if (push) begin
                    set_ovf = 1'b1;
                end else if (pop && !sp_empty) begin
                    load_rd = 1'b1;
                    sp_next = sp - 1'b1;
                end else if (pop) begin
                    set_udf = 1'b1;
                end
            end
            default: begin
                state_next = S_INIT;
                k_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            k         <= '0;
            sp        <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            state     <= state_next;
            k         <= k_next;
            sp        <= sp_next;
            count     <= sp_next;
            full      <= (sp_next == SP_FULL);
            empty     <= (sp_next == '0);
            pop_valid <= load_rd | load_byp;
            if (load_rd) begin
                pop_data <= rf_rd_data;
            end else if (load_byp) begin
                pop_data <= push_data;
            end
            if (clr_flags) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (set_ovf) ovf <= 1'b1;
                if (set_udf) udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_lifo.sv
// Bench for reg_file_lifo: fixed vector table, hand-written reset/clear sequences,
// and random traffic compared against a queue-based stack model.
module tb_reg_file_lifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] pop_data, rf_wr_data, rf_rd_data;
    logic       pop_valid, full, empty, busy, ovf, udf, rf_wr_en;
    logic [3:0] count;
    logic [2:0] rf_addr;

    reg_file_lifo #(.width(WIDTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr),
        .push_data(push_data), .pop_data(pop_data), .pop_valid(pop_valid),
        .count(count), .full(full), .empty(empty), .busy(busy),
        .ovf(ovf), .udf(udf), .rf_wr_en(rf_wr_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data)
    );

    // Register file environment: async read, synchronous write.
    logic [7:0] mem [DEPTH];
    assign rf_rd_data = mem[rf_addr];
    always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_wr_data;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stack contents as a queue, busy as remaining zero-fill cycles.
    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_pv;
    logic [7:0] m_pd;
    int         init_left;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_pv = 0; m_pd = '0;
        init_left = DEPTH;
    endfunction

    typedef struct {
        logic p, po, c;
        logic [7:0] d;
        logic e_wr;
        int   e_addr;
        logic [7:0] e_wd;
        int   e_cnt;
        logic e_busy, e_pv;
        logic [7:0] e_pd;
        logic e_ovf, e_udf;
    } vec_t;

    vec_t tbl[$];
    vec_t vnone;

    function automatic void add(logic p, logic po, logic c, logic [7:0] d, logic ew, int ea,
                                logic [7:0] ewd, int ec, logic eb, logic epv, logic [7:0] epd,
                                logic eo, logic eu);
        vec_t v;
        v.p = p; v.po = po; v.c = c; v.d = d; v.e_wr = ew; v.e_addr = ea; v.e_wd = ewd;
        v.e_cnt = ec; v.e_busy = eb; v.e_pv = epv; v.e_pd = epd; v.e_ovf = eo; v.e_udf = eu;
        tbl.push_back(v);
    endfunction

    task automatic check_reset();
        chk("rst_busy", busy, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_rf_wr_en", rf_wr_en, 1);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wr_data", rf_wr_data, 0);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic p, input logic po, input logic c, input logic [7:0] d,
                        input bit use_v, input vec_t v);
        bit         e_wr;
        int         e_addr;
        logic [7:0] e_wd;
        int         sz;
        push = p; pop = po; clr = c; push_data = d;
        #1;
        sz     = q.size();
        e_wr   = 0;
        e_addr = (sz + DEPTH - 1) % DEPTH;
        e_wd   = '0;
        if (init_left > 0) begin
            e_wr   = 1;
            e_addr = DEPTH - init_left;
        end else if (!c && p && (po ? (sz > 0) : (sz < DEPTH))) begin
            e_wr   = 1;
            e_addr = po ? sz - 1 : sz;
            e_wd   = d;
        end
        chk("rf_wr_en", rf_wr_en, e_wr);
        chk("rf_addr", rf_addr, e_addr);
        if (e_wr) chk("rf_wr_data", rf_wr_data, e_wd);
        chk("busy_pre", busy, init_left > 0);
        if (use_v) begin
            chk("tbl_rf_wr_en", rf_wr_en, v.e_wr);
            chk("tbl_rf_addr", rf_addr, v.e_addr);
            if (v.e_wr) chk("tbl_rf_wr_data", rf_wr_data, v.e_wd);
        end
        @(posedge clk);
        m_pv = 0;
        if (init_left > 0) begin
            init_left--;
        end else if (c) begin
            q.delete();
            m_ovf = 0; m_udf = 0;
            init_left = DEPTH;
        end else if (p && po) begin
            m_pv = 1;
            if (sz > 0) begin
                m_pd = q[sz-1];
                q[sz-1] = d;
            end else begin
                m_pd = d;
            end
        end else if (p) begin
            if (sz < DEPTH) q.push_back(d);
            else m_ovf = 1;
        end else if (po) begin
            if (sz > 0) begin
                m_pd = q.pop_back();
                m_pv = 1;
            end else begin
                m_udf = 1;
            end
        end
        #1;
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("busy", busy, init_left > 0);
        chk("pop_valid", pop_valid, m_pv);
        chk("pop_data", pop_data, m_pd);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        if (use_v) begin
            chk("tbl_count", count, v.e_cnt);
            chk("tbl_busy", busy, v.e_busy);
            chk("tbl_pop_valid", pop_valid, v.e_pv);
            chk("tbl_pop_data", pop_data, v.e_pd);
            chk("tbl_ovf", ovf, v.e_ovf);
            chk("tbl_udf", udf, v.e_udf);
        end
        @(negedge clk);
    endtask

    initial begin
        vnone = '{default: '0};

        // Vectors start from an empty, idle stack right after INIT.
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 8'(17 * (i + 1)), 1, i, 8'(17 * (i + 1)), i + 1, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h99, 0, 7, 8'h00, 8, 0, 0, 8'h00, 1, 0);
        for (int j = 0; j < 8; j++)
            add(0, 1, 0, 8'h00, 0, 7 - j, 8'h00, 7 - j, 0, 1, 8'(17 * (8 - j)), 1, 0);
        add(0, 1, 0, 8'h00, 0, 7, 8'h00, 0, 0, 0, 8'h11, 1, 1);
        add(1, 0, 0, 8'hA5, 1, 0, 8'hA5, 1, 0, 0, 8'h11, 1, 1);
        add(1, 0, 0, 8'h3C, 1, 1, 8'h3C, 2, 0, 0, 8'h11, 1, 1);
        add(1, 1, 0, 8'h5A, 1, 1, 8'h5A, 2, 0, 1, 8'h3C, 1, 1);
        add(0, 1, 0, 8'h00, 0, 1, 8'h00, 1, 0, 1, 8'h5A, 1, 1);
        add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 1);
        add(1, 1, 0, 8'h42, 0, 7, 8'h00, 0, 0, 1, 8'h42, 1, 1);
        add(0, 0, 0, 8'h00, 0, 7, 8'h00, 0, 0, 0, 8'h42, 1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 8'(i + 1), 1, i, 8'(i + 1), i + 1, 0, 0, 8'h42, 1, 1);
        add(1, 1, 1, 8'h77, 0, 2, 8'h00, 0, 1, 0, 8'h42, 0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 1, k[0], 8'hFF, 1, k, 8'h00, 0, k < 7, 0, 8'h42, 0, 0);
        add(0, 1, 0, 8'h00, 0, 7, 8'h00, 0, 0, 0, 8'h42, 0, 1);

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b0;
        #1 check_reset();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 8'h00, 0, vnone);
        foreach (tbl[i]) step(tbl[i].p, tbl[i].po, tbl[i].c, tbl[i].d, 1, tbl[i]);

        // Reset asserted during the third CLR cycle.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'($urandom), 0, vnone);
        step(0, 0, 1, 8'h00, 0, vnone);
        step(0, 0, 0, 8'h00, 0, vnone);
        step(0, 0, 0, 8'h00, 0, vnone);
        #2 rst = 1'b0;
        #1 check_reset();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 8'h00, 0, vnone);

        // Random traffic: push-heavy then pop-heavy phases, occasional clear.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                logic p, po, c;
                c  = ($urandom_range(0, 59) == 0);
                p  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 30));
                po = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 70));
                step(p, po, c, 8'($urandom), 0, vnone);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
